uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx` transmitter between `NUM_REQ` byte producers. Each requester offers a byte on a valid/ready handshake. The arbiter grants one requester and latches its byte. It then pulses `start_i` on the transmitter and holds the data stable until `tx_done_o` returns. The block sits directly in front of `uart_tx`, in the same clock domain.

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter-side signals of the round-robin UART TX arbiter.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]            req_valid_i;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
   logic [NUM_REQ-1:0]            req_ready_o;
   logic [DATA_WIDTH-1:0]         tx_data_o;
   logic                          tx_start_o;
   logic                          tx_done_i;
   logic [ID_WIDTH-1:0]           grant_id_o;
   logic                          busy_o;
   logic                          timeout_o;

   modport slave (
      input  req_valid_i, req_data_i, tx_done_i,
      output req_ready_o, tx_data_o, tx_start_o, grant_id_o, busy_o, timeout_o
   );

   modport master (
      output req_valid_i, req_data_i, tx_done_i,
      input  req_ready_o, tx_data_o, tx_start_o, grant_id_o, busy_o, timeout_o
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 16384,
   parameter int unsigned ID_WIDTH       = $clog2(NUM_REQ)
) (
   input logic             clk_i,
   input logic             rst_ni,
   uart_tx_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ID_WIDTH-1:0]   last_ptr_q, last_ptr_d;
   logic [ID_WIDTH-1:0]   grant_q, grant_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  start_q;
   logic                  busy_q;
   logic [NUM_REQ-1:0]    ready_c;
   logic                  timeout_c;
   logic                  found_c;
   logic [ID_WIDTH-1:0]   win_c;

   // First valid requester searching upward from last_ptr+1, wrapping.
   always_comb begin
      found_c = 1'b0;
      win_c   = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         logic [ID_WIDTH-1:0] cand;
         cand = ID_WIDTH'((32'(last_ptr_q) + off) % NUM_REQ);
         if (!found_c && bus.req_valid_i[cand]) begin
            found_c = 1'b1;
            win_c   = cand;
         end
      end
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   logic [31:0] wait_cnt_q;

   // Counts WAIT cycles; zero in the first WAIT cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                 wait_cnt_q <= '0;
      else if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q + 32'd1;
      else                         wait_cnt_q <= '0;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^(32'(TIMEOUT_CYCLES));
`endif

   always_comb begin
      state_d    = state_q;
      last_ptr_d = last_ptr_q;
      grant_d    = grant_q;
      tx_data_d  = tx_data_q;
      ready_c    = '0;
      timeout_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (found_c) begin
               ready_c[win_c] = 1'b1;
               last_ptr_d     = win_c;
               grant_d        = win_c;
               for (int unsigned k = 0; k < NUM_REQ; k++) begin
                  if (ID_WIDTH'(k) == win_c) tx_data_d = bus.req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
               end
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: state_d = ST_WAIT;
         ST_WAIT: begin
            if (bus.tx_done_i) begin
               state_d = ST_IDLE;
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            else if (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
               timeout_c = 1'b1;
               state_d   = ST_IDLE;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         last_ptr_q <= ID_WIDTH'(NUM_REQ - 1);
         grant_q    <= '0;
         tx_data_q  <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_ptr_q <= last_ptr_d;
         grant_q    <= grant_d;
         tx_data_q  <= tx_data_d;
         start_q    <= (state_d == ST_LAUNCH);
         busy_q     <= (state_d != ST_IDLE);
      end
   end

   assign bus.req_ready_o = ready_c;
   assign bus.tx_data_o   = tx_data_q;
   assign bus.tx_start_o  = start_q;
   assign bus.grant_id_o  = grant_q;
   assign bus.busy_o      = busy_q;
   assign bus.timeout_o   = timeout_c;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a done-stub transmitter.
module tb_uart_tx_arbiter;
   localparam int unsigned N  = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned IW = 2;
`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int unsigned TO = 64;
`else
   localparam int unsigned TO = 16384;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .ID_WIDTH(IW)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL global_time_limit: observed no finish, required finish");
      $fatal(1);
   end

   // Requester and arbitration reference state
   logic          pend_valid [N];
   logic [DW-1:0] pend_data  [N];
   int            wait_cnt   [N];
   int            ref_last;
   int            last_done_cyc;
   bit            gap_valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         bus.req_valid_i[k]            = pend_valid[k];
         bus.req_data_i[k*DW +: DW]    = pend_data[k];
      end
   endtask

   // Winner is the valid requester at smallest forward distance past the last grant.
   function automatic int ref_pick();
      int best = -1;
      int bestd = N;
      for (int k = 0; k < N; k++) begin
         int d = (k - ref_last - 1 + 2*N) % N;
         if (pend_valid[k] && d < bestd) begin
            best  = k;
            bestd = d;
         end
      end
      return best;
   endfunction

   function automatic logic [31:0] onehot(input int g);
      logic [31:0] v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   function automatic bit any_pending();
      bit a = 0;
      for (int k = 0; k < N; k++) a |= pend_valid[k];
      return a;
   endfunction

   task automatic wait_stim(input int eg, input bit keep);
      for (int k = 0; k < N; k++) begin
         if (!pend_valid[k]) begin
            pend_data[k] = DW'($urandom);
            if (!keep && k != eg && $urandom_range(0, 3) == 0) begin
               pend_valid[k] = 1'b1;
               wait_cnt[k]   = 0;
            end
         end
      end
   endtask

   task automatic do_reset();
      for (int k = 0; k < N; k++) begin
         pend_valid[k] = 1'b0;
         wait_cnt[k]   = 0;
      end
      bus.tx_done_i = 1'b0;
      drive();
      rst_n = 1'b0;
      #1;
      chk("rst_ready", 32'(bus.req_ready_o), 0);
      chk("rst_tx_data", 32'(bus.tx_data_o), 0);
      chk("rst_start", 32'(bus.tx_start_o), 0);
      chk("rst_grant", 32'(bus.grant_id_o), 0);
      chk("rst_busy", 32'(bus.busy_o), 0);
      chk("rst_timeout", 32'(bus.timeout_o), 0);
      tick();
      tick();
      rst_n     = 1'b1;
      ref_last  = N - 1;
      gap_valid = 0;
   endtask

   // One complete grant; hold = extra WAIT cycles before done, negative = let the watchdog fire.
   task automatic run_grant(input int hold, input bit keep, output int g);
      int          eg;
      int          t_start;
      bit          fair_ok;
      logic [DW-1:0] eb;
      if (!any_pending()) begin
         int k = $urandom_range(0, N - 1);
         pend_valid[k] = 1'b1;
         pend_data[k]  = DW'($urandom);
         wait_cnt[k]   = 0;
      end
      drive();
      #1;
      eg = ref_pick();
      chk("ready_onehot", 32'(bus.req_ready_o), onehot(eg));
      eb = pend_data[eg];
      tick();
      fair_ok = 1;
      for (int k = 0; k < N; k++) begin
         if (k != eg && pend_valid[k]) begin
            wait_cnt[k]++;
            if (wait_cnt[k] > N - 1) fair_ok = 0;
         end
      end
      chk("fairness", 32'(fair_ok), 1);
      ref_last     = eg;
      wait_cnt[eg] = 0;
      if (!keep) pend_valid[eg] = 1'b0;
      drive();
      #1;
      chk("start_pulse", 32'(bus.tx_start_o), 1);
      chk("grant_id", 32'(bus.grant_id_o), 32'(eg));
      chk("tx_data", 32'(bus.tx_data_o), 32'(eb));
      chk("busy_launch", 32'(bus.busy_o), 1);
      chk("ready_launch", 32'(bus.req_ready_o), 0);
      if (gap_valid) chk("done_to_start", 32'(cyc - last_done_cyc), 2);
      t_start = cyc;
      if (hold >= 0) begin
         repeat (hold) begin
            tick();
            wait_stim(eg, keep);
            drive();
            #1;
            chk("hold_data", 32'(bus.tx_data_o), 32'(eb));
            chk("hold_grant", 32'(bus.grant_id_o), 32'(eg));
            chk("ready_wait", 32'(bus.req_ready_o), 0);
            chk("start_low", 32'(bus.tx_start_o), 0);
            chk("timeout_low", 32'(bus.timeout_o), 0);
         end
         tick();
         bus.tx_done_i = 1'b1;
         wait_stim(eg, keep);
         drive();
         #1;
         chk("done_no_timeout", 32'(bus.timeout_o), 0);
         chk("busy_at_done", 32'(bus.busy_o), 1);
         last_done_cyc = cyc;
         tick();
         bus.tx_done_i = 1'b0;
         #1;
         chk("busy_after_done", 32'(bus.busy_o), 0);
      end else begin
         repeat (TO - 1) begin
            tick();
            wait_stim(eg, keep);
            drive();
            #1;
            chk("wd_quiet", 32'(bus.timeout_o), 0);
         end
         tick();
         #1;
         chk("wd_pulse", 32'(bus.timeout_o), 1);
         chk("wd_latency", 32'(cyc - t_start), 32'(TO));
         chk("wd_busy_held", 32'(bus.busy_o), 1);
         last_done_cyc = cyc;
         tick();
         #1;
         chk("wd_pulse_end", 32'(bus.timeout_o), 0);
         chk("wd_busy_fall", 32'(bus.busy_o), 0);
      end
      gap_valid = 1;
      if (!keep && $urandom_range(0, 1) == 1) begin
         pend_valid[eg] = 1'b1;
         wait_cnt[eg]   = 0;
      end
      g = eg;
   endtask

   initial begin
      int g;
      rst_n         = 1'b0;
      bus.tx_done_i = 1'b0;
      for (int k = 0; k < N; k++) pend_data[k] = '0;

      // Single request from requester 2
      do_reset();
      tick();
      pend_valid[2] = 1'b1;
      pend_data[2]  = 8'hA5;
      run_grant(3, 0, g);
      chk("single_gid", 32'(g), 2);

      // All four held valid: strict rotation from 0
      do_reset();
      tick();
      for (int k = 0; k < N; k++) begin
         pend_valid[k] = 1'b1;
         pend_data[k]  = DW'(8'h10 + k);
      end
      for (int i = 0; i < 5; i++) begin
         run_grant(2, 1, g);
         chk("rr_order", 32'(g), 32'(i % N));
      end

      // Two requesters, done 20 cycles after start
      do_reset();
      tick();
      pend_valid[1] = 1'b1;
      pend_data[1]  = DW'($urandom);
      pend_valid[3] = 1'b1;
      pend_data[3]  = DW'($urandom);
      for (int i = 0; i < 4; i++) begin
         run_grant(19, 1, g);
         chk("b2b_order", 32'(g), (i % 2 == 0) ? 32'd1 : 32'd3);
      end

      // Reset five cycles into WAIT, then a stray done
      do_reset();
      tick();
      pend_valid[1] = 1'b1;
      pend_data[1]  = DW'($urandom);
      drive();
      tick();
      pend_valid[1] = 1'b0;
      drive();
      repeat (6) tick();
      chk("mid_busy_before", 32'(bus.busy_o), 1);
      do_reset();
      tick();
      bus.tx_done_i = 1'b1;
      tick();
      bus.tx_done_i = 1'b0;
      repeat (3) begin
         tick();
         chk("stray_start", 32'(bus.tx_start_o), 0);
         chk("stray_busy", 32'(bus.busy_o), 0);
      end
      for (int k = 0; k < N; k++) begin
         pend_valid[k] = 1'b1;
         pend_data[k]  = DW'($urandom);
      end
      run_grant(1, 0, g);
      chk("post_reset_first", 32'(g), 0);

      // Randomized traffic
      for (int i = 0; i < 40; i++) run_grant($urandom_range(0, 6), 0, g);

`ifdef UART_TX_ARB_TIMEOUT_EN
      run_grant(-1, 0, g);
      run_grant(TO - 1, 0, g);
      run_grant(2, 0, g);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
